// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: Execute > LSU > debug, with an LSU starvation guard
// that stalls Execute. The granted write is registered onto the port one cycle later.
module rf_wr_arbiter #(
  parameter int REG_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT  = 4,
  parameter int DISCARD_R0    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exe_wr_en,
  input  logic [RF_ADDR_WIDTH-1:0] exe_wr_addr,
  input  logic [REG_WIDTH-1:0]     exe_wr_val,
  output logic                     exe_stall,
  input  logic                     lsu_wr_valid,
  output logic                     lsu_wr_ready,
  input  logic [RF_ADDR_WIDTH-1:0] lsu_wr_addr,
  input  logic [REG_WIDTH-1:0]     lsu_wr_val,
  input  logic                     dbg_wr_req,
  input  logic [RF_ADDR_WIDTH-1:0] dbg_wr_addr,
  input  logic [REG_WIDTH-1:0]     dbg_wr_val,
  output logic                     dbg_wr_ack,
  output logic                     rf_wr_en,
  output logic [RF_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [REG_WIDTH-1:0]     rf_wr_val
);

  typedef enum logic [1:0] {DBG_IDLE, DBG_ISSUE, DBG_WAIT} dbg_state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
  endfunction

  dbg_state_t               r_dbg_state;
  logic [3:0]               r_starve;
  logic                     r_exe_stall;
  logic                     r_dbg_ack_p1;
  logic                     r_vld_p1;
  logic [RF_ADDR_WIDTH-1:0] r_addr_p1;
  logic [REG_WIDTH-1:0]     r_val_p1;

  logic                     w_lsu_ready;
  logic                     w_lsu_xfer;
  logic                     w_exe_gnt;
  logic                     w_dbg_gnt;
  logic                     w_vld_p0;
  logic [RF_ADDR_WIDTH-1:0] w_addr_p0;
  logic [REG_WIDTH-1:0]     w_val_p0;
  logic [3:0]               w_starve_nxt;

  // p0: grant selection; during a stall the LSU outranks Execute
  always_comb begin
    w_lsu_ready = lsu_wr_valid & ~rst & (~exe_wr_en | r_exe_stall);
    w_lsu_xfer  = lsu_wr_valid & w_lsu_ready;
    w_exe_gnt   = exe_wr_en & ~r_exe_stall & ~rst;
    w_dbg_gnt   = (r_dbg_state == DBG_ISSUE) & dbg_wr_req & ~exe_wr_en & ~w_lsu_xfer & ~rst;
    w_vld_p0    = w_lsu_xfer | w_exe_gnt | w_dbg_gnt;
    w_addr_p0   = dbg_wr_addr;
    w_val_p0    = dbg_wr_val;
    if (w_lsu_xfer) begin
      w_addr_p0 = lsu_wr_addr;
      w_val_p0  = lsu_wr_val;
    end else if (w_exe_gnt) begin
      w_addr_p0 = exe_wr_addr;
      w_val_p0  = exe_wr_val;
    end
    if (!lsu_wr_valid || w_lsu_xfer) w_starve_nxt = 4'd0;
    else                             w_starve_nxt = sat_inc(r_starve);
  end

  // p1: registered port, stall and debug handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbg_state  <= DBG_IDLE;
      r_starve     <= 4'd0;
      r_exe_stall  <= 1'b0;
      r_dbg_ack_p1 <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_addr_p1    <= '0;
      r_val_p1     <= '0;
    end else begin
      r_starve     <= w_starve_nxt;
      r_exe_stall  <= (w_starve_nxt == LIMIT);
      r_dbg_ack_p1 <= w_dbg_gnt;
      r_vld_p1     <= w_vld_p0 & ~((DISCARD_R0 != 0) && (w_addr_p0 == '0));
      if (w_vld_p0) begin
        r_addr_p1 <= w_addr_p0;
        r_val_p1  <= w_val_p0;
      end
      case (r_dbg_state)
        DBG_IDLE:  if (dbg_wr_req) r_dbg_state <= DBG_ISSUE;
        DBG_ISSUE: begin
          if (!dbg_wr_req)    r_dbg_state <= DBG_IDLE;
          else if (w_dbg_gnt) r_dbg_state <= DBG_WAIT;
        end
        DBG_WAIT:  if (!dbg_wr_req) r_dbg_state <= DBG_IDLE;
        default:   r_dbg_state <= DBG_IDLE;
      endcase
    end
  end

  assign lsu_wr_ready = w_lsu_ready;
  assign exe_stall    = r_exe_stall;
  assign dbg_wr_ack   = r_dbg_ack_p1;
  assign rf_wr_en     = r_vld_p1;
  assign rf_wr_addr   = r_addr_p1;
  assign rf_wr_val    = r_val_p1;

  // Execute writing while told to stall loses its write to the LSU
  a_exe_while_stall: assert property (@(posedge clk) disable iff (rst) !(exe_wr_en && r_exe_stall));

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a behavioural port model.
module tb_rf_wr_arbiter;
  localparam int RW = 32;
  localparam int AW = 5;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exe_wr_en = 1'b0;
  logic [AW-1:0] exe_wr_addr = '0;
  logic [RW-1:0] exe_wr_val = '0;
  logic          lsu_wr_valid = 1'b0;
  logic [AW-1:0] lsu_wr_addr = '0;
  logic [RW-1:0] lsu_wr_val = '0;
  logic          dbg_wr_req = 1'b0;
  logic [AW-1:0] dbg_wr_addr = '0;
  logic [RW-1:0] dbg_wr_val = '0;

  logic          exe_stall0, lsu_wr_ready0, dbg_wr_ack0, rf_wr_en0;
  logic [AW-1:0] rf_wr_addr0;
  logic [RW-1:0] rf_wr_val0;
  logic          exe_stall1, lsu_wr_ready1, dbg_wr_ack1, rf_wr_en1;
  logic [AW-1:0] rf_wr_addr1;
  logic [RW-1:0] rf_wr_val1;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.REG_WIDTH(RW), .RF_ADDR_WIDTH(AW), .STARVE_LIMIT(LIM), .DISCARD_R0(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .exe_wr_en(exe_wr_en), .exe_wr_addr(exe_wr_addr), .exe_wr_val(exe_wr_val), .exe_stall(exe_stall0),
    .lsu_wr_valid(lsu_wr_valid), .lsu_wr_ready(lsu_wr_ready0), .lsu_wr_addr(lsu_wr_addr), .lsu_wr_val(lsu_wr_val),
    .dbg_wr_req(dbg_wr_req), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_val(dbg_wr_val), .dbg_wr_ack(dbg_wr_ack0),
    .rf_wr_en(rf_wr_en0), .rf_wr_addr(rf_wr_addr0), .rf_wr_val(rf_wr_val0));

  rf_wr_arbiter #(.REG_WIDTH(RW), .RF_ADDR_WIDTH(AW), .STARVE_LIMIT(LIM), .DISCARD_R0(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .exe_wr_en(exe_wr_en), .exe_wr_addr(exe_wr_addr), .exe_wr_val(exe_wr_val), .exe_stall(exe_stall1),
    .lsu_wr_valid(lsu_wr_valid), .lsu_wr_ready(lsu_wr_ready1), .lsu_wr_addr(lsu_wr_addr), .lsu_wr_val(lsu_wr_val),
    .dbg_wr_req(dbg_wr_req), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_val(dbg_wr_val), .dbg_wr_ack(dbg_wr_ack1),
    .rf_wr_en(rf_wr_en1), .rf_wr_addr(rf_wr_addr1), .rf_wr_val(rf_wr_val1));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the port shows in the next cycle given this cycle's requests.
  bit            chk_en = 1'b0;
  bit            m_gnt = 1'b0, m_en = 1'b0, m_stall = 1'b0, m_ack = 1'b0, m_last_xfer = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [RW-1:0] m_val = '0;
  int            m_losses = 0;
  int            m_dbg = 0;   // 0: no request seen, 1: waiting for a free slot, 2: written

  always @(negedge clk) begin
    bit ready_exp, xfer, exe_win, dbg_win;
    ready_exp = lsu_wr_valid && !rst && (!exe_wr_en || m_stall);
    if (chk_en) begin
      chk("rf_wr_en",     {31'd0, rf_wr_en0},    {31'd0, m_en});
      chk("rf_wr_addr",   {27'd0, rf_wr_addr0},  {27'd0, m_addr});
      chk("rf_wr_val",    rf_wr_val0,            m_val);
      chk("exe_stall",    {31'd0, exe_stall0},   {31'd0, m_stall});
      chk("dbg_wr_ack",   {31'd0, dbg_wr_ack0},  {31'd0, m_ack});
      chk("lsu_wr_ready", {31'd0, lsu_wr_ready0}, {31'd0, ready_exp});
      chk("nodisc_en",    {31'd0, rf_wr_en1},    {31'd0, m_gnt});
      chk("nodisc_addr",  {27'd0, rf_wr_addr1},  {27'd0, m_addr});
    end
    if (rst) begin
      m_gnt = 0; m_en = 0; m_stall = 0; m_ack = 0; m_last_xfer = 0;
      m_addr = '0; m_val = '0; m_losses = 0; m_dbg = 0;
    end else begin
      xfer    = lsu_wr_valid && ready_exp;
      exe_win = exe_wr_en && !m_stall;
      dbg_win = (m_dbg == 1) && dbg_wr_req && !exe_wr_en && !xfer;
      m_gnt   = xfer || exe_win || dbg_win;
      if (xfer)         begin m_addr = lsu_wr_addr; m_val = lsu_wr_val; end
      else if (exe_win) begin m_addr = exe_wr_addr; m_val = exe_wr_val; end
      else if (dbg_win) begin m_addr = dbg_wr_addr; m_val = dbg_wr_val; end
      m_en = m_gnt && (m_addr != 0);
      if (!lsu_wr_valid || xfer) m_losses = 0;
      else if (m_losses < LIM)   m_losses = m_losses + 1;
      m_stall = (m_losses == LIM);
      m_ack = dbg_win;
      m_last_xfer = xfer;
      if (!dbg_wr_req)   m_dbg = 0;
      else if (dbg_win)  m_dbg = 2;
      else if (m_dbg == 0) m_dbg = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acked = 0;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset en",    {31'd0, rf_wr_en0}, 32'd0);
    chk("reset addr",  {27'd0, rf_wr_addr0}, 32'd0);
    chk("reset val",   rf_wr_val0, 32'd0);
    chk("reset stall", {31'd0, exe_stall0}, 32'd0);
    chk("reset ack",   {31'd0, dbg_wr_ack0}, 32'd0);
    rst = 1'b0;
    tick();

    // single Execute write
    exe_wr_en = 1; exe_wr_addr = 5'd5; exe_wr_val = 32'hDEADBEEF;
    tick();
    exe_wr_en = 0;
    chk("exe en",    {31'd0, rf_wr_en0}, 32'd1);
    chk("exe addr",  {27'd0, rf_wr_addr0}, 32'd5);
    chk("exe val",   rf_wr_val0, 32'hDEADBEEF);
    chk("exe stall", {31'd0, exe_stall0}, 32'd0);
    tick();
    chk("idle en",   {31'd0, rf_wr_en0}, 32'd0);
    chk("hold addr", {27'd0, rf_wr_addr0}, 32'd5);

    // Execute and LSU collide
    exe_wr_en = 1; exe_wr_addr = 5'd3; exe_wr_val = 32'h33;
    lsu_wr_valid = 1; lsu_wr_addr = 5'd4; lsu_wr_val = 32'h44;
    #1 chk("coll ready0", {31'd0, lsu_wr_ready0}, 32'd0);
    tick();
    exe_wr_en = 0;
    #1 chk("coll ready1", {31'd0, lsu_wr_ready0}, 32'd1);
    chk("coll w1 addr", {27'd0, rf_wr_addr0}, 32'd3);
    chk("coll w1 val",  rf_wr_val0, 32'h33);
    tick();
    lsu_wr_valid = 0;
    chk("coll w2 en",   {31'd0, rf_wr_en0}, 32'd1);
    chk("coll w2 addr", {27'd0, rf_wr_addr0}, 32'd4);
    chk("coll w2 val",  rf_wr_val0, 32'h44);
    tick();

    // starvation guard
    lsu_wr_valid = 1; lsu_wr_addr = 5'd9; lsu_wr_val = 32'h99;
    for (int i = 0; i < 4; i++) begin
      exe_wr_en = 1; exe_wr_addr = 5'(10 + i); exe_wr_val = 32'(i);
      tick();
      chk("starve stall", {31'd0, exe_stall0}, {31'd0, (i == 3)});
    end
    exe_wr_en = 0;
    #1 chk("starve ready", {31'd0, lsu_wr_ready0}, 32'd1);
    tick();
    lsu_wr_valid = 0;
    chk("starve addr",  {27'd0, rf_wr_addr0}, 32'd9);
    chk("starve val",   rf_wr_val0, 32'h99);
    chk("starve clear", {31'd0, exe_stall0}, 32'd0);
    tick();

    // debug write amid traffic
    dbg_wr_req = 1; dbg_wr_addr = 5'd7; dbg_wr_val = 32'h1234;
    exe_wr_en = 1; exe_wr_addr = 5'd1; exe_wr_val = 32'h11;
    tick();
    chk("dbg ack B", {31'd0, dbg_wr_ack0}, 32'd0);
    tick();
    exe_wr_en = 0;
    lsu_wr_valid = 1; lsu_wr_addr = 5'd2; lsu_wr_val = 32'h22;
    chk("dbg ack C", {31'd0, dbg_wr_ack0}, 32'd0);
    tick();
    lsu_wr_valid = 0;
    chk("dbg lsu addr", {27'd0, rf_wr_addr0}, 32'd2);
    chk("dbg ack D", {31'd0, dbg_wr_ack0}, 32'd0);
    tick();
    chk("dbg en",   {31'd0, rf_wr_en0}, 32'd1);
    chk("dbg addr", {27'd0, rf_wr_addr0}, 32'd7);
    chk("dbg val",  rf_wr_val0, 32'h1234);
    chk("dbg ack",  {31'd0, dbg_wr_ack0}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dbg no repeat en",  {31'd0, rf_wr_en0}, 32'd0);
      chk("dbg no repeat ack", {31'd0, dbg_wr_ack0}, 32'd0);
    end
    dbg_wr_req = 0;
    tick();

    // write to r0
    lsu_wr_valid = 1; lsu_wr_addr = 5'd0; lsu_wr_val = 32'h55;
    #1 chk("r0 ready", {31'd0, lsu_wr_ready0}, 32'd1);
    tick();
    lsu_wr_valid = 0;
    chk("r0 discard en", {31'd0, rf_wr_en0}, 32'd0);
    chk("r0 keep en",    {31'd0, rf_wr_en1}, 32'd1);
    chk("r0 keep addr",  {27'd0, rf_wr_addr1}, 32'd0);
    tick();

    // reset while stalled with debug pending
    lsu_wr_valid = 1; lsu_wr_addr = 5'd3; lsu_wr_val = 32'h77;
    dbg_wr_req = 1; dbg_wr_addr = 5'h11; dbg_wr_val = 32'hABCD;
    for (int i = 0; i < 4; i++) begin
      exe_wr_en = 1; exe_wr_addr = 5'(20 + i); exe_wr_val = 32'(i + 100);
      tick();
    end
    chk("rst pre stall", {31'd0, exe_stall0}, 32'd1);
    exe_wr_en = 0; rst = 1;
    tick();
    rst = 0; lsu_wr_valid = 0;
    chk("rst en",    {31'd0, rf_wr_en0}, 32'd0);
    chk("rst addr",  {27'd0, rf_wr_addr0}, 32'd0);
    chk("rst val",   rf_wr_val0, 32'd0);
    chk("rst stall", {31'd0, exe_stall0}, 32'd0);
    chk("rst ack",   {31'd0, dbg_wr_ack0}, 32'd0);
    tick();
    chk("rearb idle en", {31'd0, rf_wr_en0}, 32'd0);
    tick();
    chk("rearb en",   {31'd0, rf_wr_en0}, 32'd1);
    chk("rearb addr", {27'd0, rf_wr_addr0}, 32'h11);
    chk("rearb ack",  {31'd0, dbg_wr_ack0}, 32'd1);
    dbg_wr_req = 0;
    tick();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (lsu_wr_valid && m_last_xfer) lsu_wr_valid = 0;
      if (!lsu_wr_valid && ($urandom_range(0, 2) == 0)) begin
        lsu_wr_valid = 1;
        lsu_wr_addr  = 5'($urandom_range(0, 7));
        lsu_wr_val   = $urandom;
      end
      exe_wr_en   = m_stall ? 1'b0 : 1'($urandom_range(0, 1));
      exe_wr_addr = 5'($urandom_range(0, 7));
      exe_wr_val  = $urandom;
      if (m_ack) acked = 1;
      if (dbg_wr_req) begin
        if (acked ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 29) == 0)) begin
          dbg_wr_req = 0;
          acked = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        dbg_wr_req  = 1;
        dbg_wr_addr = 5'($urandom_range(0, 7));
        dbg_wr_val  = $urandom;
        acked = 0;
      end
      tick();
    end
    rst = 0; exe_wr_en = 0; lsu_wr_valid = 0; dbg_wr_req = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
